// File: rtl/fp_div_seq.sv
// fp_div_seq: multi-cycle IEEE-754 divider that produces one restoring-divide
// quotient bit per clock. Only one operation is in flight at a time.
//
// Optional feature macro: FP_DIV_RNE_EN
//   defined   -> round to nearest, ties to even
//   undefined -> truncate toward zero (guard/sticky only drive inexact)
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands valid
//   in_ready   block idle and able to accept
//   dnd        dividend {sign, exponent, fraction}
//   der        divisor  {sign, exponent, fraction}
//   out_valid  result valid, held until taken
//   out_ready  consumer takes result
//   quo        quotient
//   flags      {invalid, div_zero, overflow, underflow, inexact}
module fp_div_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W+MAN_W:0]     dnd,
  input  logic [EXP_W+MAN_W:0]     der,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     quo,
  output logic [4:0]               flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int QW   = MAN_W + 3;          // integer bit + MAN_W + guard + one extra
  localparam int EW   = EXP_W + 2;
  localparam int CW   = $clog2(QW + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]        CLAST = CW'(QW - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [W-1:0]            a_q, a_d, b_q, b_d;
  logic [MAN_W+1:0]        rem_q, rem_d;
  logic [MAN_W:0]          mb_q, mb_d;
  logic [QW-1:0]           acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [EW-1:0]    exp_q, exp_d;
  logic                    sign_q, sign_d;
  logic                    spec_q, spec_d;
  logic [W-1:0]            spec_res_q, spec_res_d;
  logic [4:0]              spec_flg_q, spec_flg_d;
  logic [W-1:0]            quo_q, quo_d;
  logic [4:0]              flags_q, flags_d;

  // Combinational scratch values
  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn;
  logic [MAN_W+1:0]        diff;
  logic                    qbit;
  logic [MAN_W-1:0]        frac;
  logic                    g, s;
  logic signed [EW-1:0]    e_n, e_r;
  logic [MAN_W:0]          frac_r;

  function automatic logic round_inc(input logic guard, input logic sticky, input logic lsb);
`ifdef FP_DIV_RNE_EN
    return guard & (sticky | lsb);
`else
    return 1'b0;
`endif
  endfunction

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quo       = quo_q;
  assign flags     = flags_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    mb_d       = mb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    sign_d     = sign_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    spec_flg_d = spec_flg_q;
    quo_d      = quo_q;
    flags_d    = flags_q;
    ea = a_q[W-2:MAN_W];
    eb = b_q[W-2:MAN_W];
    fa = a_q[MAN_W-1:0];
    fb = b_q[MAN_W-1:0];
    // Subnormals have a zero exponent and are flushed to zero here
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (&ea) && (fa == '0);
    b_inf  = (&eb) && (fb == '0);
    a_nan  = (&ea) && (fa != '0);
    b_nan  = (&eb) && (fb != '0);
    sgn    = a_q[W-1] ^ b_q[W-1];
    diff   = rem_q;
    qbit   = 1'b0;
    frac   = '0;
    g      = 1'b0;
    s      = 1'b0;
    e_n    = exp_q;
    e_r    = exp_q;
    frac_r = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = dnd;
          b_d     = der;
          state_d = S_PREP;
        end
      end

      // ---- PREP: unpack, classify, exponent difference ----
      S_PREP: begin
        rem_d  = a_zero ? '0 : {2'b01, fa};
        mb_d   = b_zero ? '0 : {1'b1, fb};
        acc_d  = '0;
        cnt_d  = '0;
        sign_d = sgn;
        exp_d  = $signed({2'b00, ea}) - $signed({2'b00, eb}) + $signed(EW'(BIAS));
        spec_d     = 1'b1;
        spec_res_d = '0;
        spec_flg_d = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          spec_res_d = QNAN;
          spec_flg_d = 5'b10000;
        end else if (b_zero && !a_inf) begin
          spec_res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          spec_flg_d = 5'b01000;
        end else if (a_inf) begin
          spec_res_d = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (a_zero || b_inf) begin
          spec_res_d = {sgn, {(W-1){1'b0}}};
        end else begin
          spec_d = 1'b0;
        end
        state_d = S_ITER;
      end

      // ---- ITER: one restoring quotient bit per cycle ----
      S_ITER: begin
        if (rem_q >= {1'b0, mb_q}) begin
          diff = rem_q - {1'b0, mb_q};
          qbit = 1'b1;
        end
        // diff < divisor here, so its top bit is always clear
        rem_d = {diff[MAN_W:0], 1'b0};
        acc_d = {acc_q[QW-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CLAST) state_d = S_ROUND;
      end

      // ---- ROUND: normalise, round, range-check, pack ----
      S_ROUND: begin
        if (acc_q[QW-1]) begin
          frac = acc_q[QW-2:2];
          g    = acc_q[1];
          s    = acc_q[0] | (|rem_q);
          e_n  = exp_q;
        end else begin
          frac = acc_q[QW-3:1];
          g    = acc_q[0];
          s    = |rem_q;
          e_n  = exp_q - EW'(1);
        end
        frac_r = {1'b0, frac} + (MAN_W+1)'(round_inc(g, s, frac[0]));
        // A carry out leaves the fraction all-zero and bumps the exponent
        e_r    = e_n + $signed({{(EW-1){1'b0}}, frac_r[MAN_W]});
        if (spec_q) begin
          quo_d   = spec_res_q;
          flags_d = spec_flg_q;
        end else if (e_r >= EMAX) begin
          quo_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          flags_d = 5'b00101;
        end else if (e_r <= 0) begin
          quo_d   = {sign_q, {(W-1){1'b0}}};
          flags_d = 5'b00011;
        end else begin
          quo_d   = {sign_q, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
          flags_d = {4'b0000, g | s};
        end
        state_d = S_DONE;
      end

      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      quo_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      flags_q <= flags_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q        <= a_d;
    b_q        <= b_d;
    rem_q      <= rem_d;
    mb_q       <= mb_d;
    acc_q      <= acc_d;
    cnt_q      <= cnt_d;
    exp_q      <= exp_d;
    sign_q     <= sign_d;
    spec_q     <= spec_d;
    spec_res_q <= spec_res_d;
    spec_flg_q <= spec_flg_d;
  end

endmodule
